// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants used by the instruction fetch unit,
// its memory interface and the test bench.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] PC_INCR     = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory port: valid/ready request channel plus a valid-only
// response channel (one outstanding request at a time).
interface instruction_fetch_unit_if;
  import riscv_fetch_pkg::*;

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [INSTR_WIDTH-1:0] imem_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem and
// writes it into the instruction register, honouring decode stalls and redirects.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                     if_clk,
  input  logic                     if_rst_n,
  input  logic                     fetch_en,
  input  logic                     ir_stall,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  instruction_fetch_unit_if.master imem,
  output logic [INSTR_WIDTH-1:0]   ir_data,
  output logic                     ir_wr_en,
  output logic [XLEN-1:0]          ir_pc,
  output logic                     misalign_err
);

  fetch_state_t           state, next_state;
  logic [XLEN-1:0]        pc, next_pc;
  logic [XLEN-1:0]        req_pc, next_req_pc;
  logic                   discard, next_discard;
  logic [INSTR_WIDTH-1:0] hold_data;
  logic [XLEN-1:0]        hold_pc;

  logic                   handshake;
  logic                   deliver;
  logic                   capture;
  logic [INSTR_WIDTH-1:0] deliver_data;
  logic [XLEN-1:0]        deliver_pc;
  fetch_state_t           resume_state;

  // Normal sequencing first; a redirect then overrides pc and cancels any
  // delivery or capture of a word that belongs to the old instruction stream.
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    next_req_pc  = req_pc;
    next_discard = discard;
    deliver      = 1'b0;
    capture      = 1'b0;
    deliver_data = hold_data;
    deliver_pc   = hold_pc;
    handshake    = (state == REQ) && imem.imem_req_ready;
    resume_state = fetch_en ? REQ : IDLE;

    case (state)
      IDLE: begin
        if (fetch_en) next_state = REQ;
      end
      REQ: begin
        if (handshake) begin
          next_req_pc = pc;
          next_pc     = pc + PC_INCR;
          next_state  = WAIT;
        end else if (!fetch_en) begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (discard) begin
            next_discard = 1'b0;
            next_state   = resume_state;
          end else if (!ir_stall) begin
            deliver      = 1'b1;
            deliver_data = imem.imem_rsp_data;
            deliver_pc   = req_pc;
            next_state   = resume_state;
          end else begin
            capture    = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (!ir_stall) begin
          deliver    = 1'b1;
          next_state = resume_state;
        end
      end
      default: next_state = IDLE;
    endcase

    if (redirect_valid) begin
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
      deliver = 1'b0;
      capture = 1'b0;
      case (state)
        REQ: begin
          if (handshake) begin
            next_discard = 1'b1;
            next_state   = WAIT;
          end else begin
            next_state = REQ;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            next_discard = 1'b0;
            next_state   = resume_state;
          end else begin
            next_discard = 1'b1;
            next_state   = WAIT;
          end
        end
        HOLD:    next_state = resume_state;
        default: ;
      endcase
    end
  end

  // Every output is registered from the next-state values, so imem_req_valid
  // tracks the REQ state exactly and imem_addr always shows the live pc.
  always_ff @(posedge if_clk or negedge if_rst_n) begin
    if (!if_rst_n) begin
      state               <= IDLE;
      pc                  <= RESET_PC;
      req_pc              <= RESET_PC;
      discard             <= 1'b0;
      hold_data           <= NOP_INSTR;
      hold_pc             <= '0;
      imem.imem_req_valid <= 1'b0;
      imem.imem_addr      <= RESET_PC;
      ir_data             <= '0;
      ir_wr_en            <= 1'b0;
      ir_pc               <= '0;
      misalign_err        <= 1'b0;
    end else begin
      state               <= next_state;
      pc                  <= next_pc;
      req_pc              <= next_req_pc;
      discard             <= next_discard;
      if (capture) begin
        hold_data <= imem.imem_rsp_data;
        hold_pc   <= req_pc;
      end
      imem.imem_req_valid <= (next_state == REQ);
      imem.imem_addr      <= next_pc;
      ir_wr_en            <= deliver;
      if (deliver) begin
        ir_data <= deliver_data;
        ir_pc   <= deliver_pc;
      end
      misalign_err        <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Writer side of the instruction register. Owns the PC and issues word reads to instruction memory over a valid/ready request and valid response interface.
- Delivers each fetched word with a one-cycle ir_wr_en pulse. Supports a decode stall and branch/jump redirect.
- Sits between imem and the instruction register. The IR's own reset is separate.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- if_clk  input  1  clock, rising edge
- if_rst_n  input  1  asynchronous active-low reset
- fetch_en  input  1  permits new requests
- ir_stall  input  1  downstream cannot accept an instruction this cycle
- redirect_valid  input  1  load new PC (branch/jump)
- redirect_pc  input  32  target PC; bits [1:0] ignored
- imem_req_valid  output  1  request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  word-aligned request address
- imem_rsp_valid  input  1  response data valid
- imem_rsp_data  input  32  instruction word
- ir_data  output  32  instruction to IR (drives ir_in)
- ir_wr_en  output  1  one-cycle write pulse to IR
- ir_pc  output  32  PC of instruction in ir_data
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC; state=IDLE; discard=0.
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, ir_data=0, ir_wr_en=0, ir_pc=0, misalign_err=0.
- All outputs are registered.

States:
- IDLE: no request. Go to REQ when fetch_en=1.
- REQ: imem_req_valid=1, imem_addr=pc. Address is held stable until the handshake. On imem_req_ready: req_pc<=pc, pc<=pc+4 (wraps modulo 2^32), go to WAIT.
- WAIT: wait for imem_rsp_valid. Only one request is outstanding.
  - If discard=1: drop the word, clear discard, go to REQ if fetch_en else IDLE.
  - Else if ir_stall=0: next cycle ir_wr_en=1, ir_data=rsp, ir_pc=req_pc; go to REQ if fetch_en else IDLE.
  - Else: capture word and req_pc into the hold buffer, go to HOLD.
- HOLD: when ir_stall=0, pulse ir_wr_en with the buffered word and PC, then go to REQ or IDLE as above.

Throughput and latency:
- Peak rate is one instruction per 2 cycles with zero-wait memory (REQ, then WAIT with rsp).
- ir_wr_en rises the cycle after rsp accept or stall release.
- ir_wr_en is high for exactly 1 cycle per delivered instruction.

Redirect (highest priority, any state):
- pc<={redirect_pc[31:2],2'b00}.
- misalign_err=1 next cycle if redirect_pc[1:0]!=0.
- In WAIT: set discard, stay in WAIT.
- In REQ with a handshake in the same cycle: the accepted request is stale, so set discard and go to WAIT. pc then takes the redirect target, not pc+4.
- In REQ without a handshake: imem_addr updates next cycle and imem_req_valid stays high.
- In HOLD: drop the buffer, go to REQ if fetch_en else IDLE.
- In IDLE: only pc is updated.
- A redirect in the same cycle as rsp_valid in WAIT drops that rsp. No ir_wr_en is issued for it, and the FSM goes to REQ or IDLE.
- ir_wr_en is never asserted in the cycle following a redirect for a stale word.

Other boundaries:
- fetch_en deasserting in REQ without a handshake: return to IDLE and drop imem_req_valid.
- fetch_en deasserting in WAIT or HOLD: the pending instruction still completes.
- ir_stall is ignored outside WAIT and HOLD.
- Reset asserted mid-transaction: immediate return to reset values. A later stray imem_rsp_valid in IDLE or REQ is ignored.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - INSTR_WIDTH=32
  - PC_INCR=32'd4
  - NOP_INSTR=32'h0000_0013
- No sub-module. The hold buffer is two 32-bit registers inside the FSM.

Test Plan:
- Reset then fetch_en=1, zero-wait memory returning addr^32'hA5A5_0000 → ir_wr_en pulses with ir_pc=0,4,8,C and ir_data=A5A5_0000, A5A5_0004, A5A5_0008, A5A5_000C.
- imem_req_ready low 3 cycles at addr 0x10 → imem_addr stays 0x10 and valid stays high; one delivery, then next addr is 0x14.
- ir_stall=1 for 4 cycles when rsp 0xDEADBEEF arrives for pc 0x20 → no pulse while stalled; single pulse with data 0xDEADBEEF, ir_pc 0x20 after release.
- redirect_pc=0x100 while WAIT for 0x24 → rsp for 0x24 dropped; next request addr 0x100; next ir_pc=0x100.
- redirect_pc=0x203 → misalign_err pulse; fetch from 0x200.
- pc=0xFFFF_FFFC fetch → delivered ir_pc=0xFFFF_FFFC, next addr 0x0000_0000. Separately, if_rst_n low in WAIT → all outputs reset; post-reset fetch starts at RESET_PC.
